// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division bit: shift in the next dividend bit, trial subtract, restore on borrow.
module seq_divider_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_c,
  output logic             o_q_c
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_dvd_msb};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_q_c   = ~w_diff[WIDTH];
  assign o_rem_c = o_q_c ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient} with a ready pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 busy,
  output logic                 div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e         r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [WIDTH-1:0]   r_rem, w_rem;
  logic [WIDTH-1:0]   r_dvd, w_dvd;
  logic [WIDTH-1:0]   r_dsr, w_dsr;
  logic               r_neg_q, w_neg_q;
  logic               r_neg_r, w_neg_r;
  logic [2*WIDTH-1:0] r_result, w_result;
  logic               r_ready, w_ready;
  logic               r_busy, w_busy;
  logic               r_dz, w_dz;

  logic [WIDTH-1:0]   w_step_rem;
  logic               w_step_q;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_dsr),
    .o_rem_c   (w_step_rem),
    .o_q_c     (w_step_q)
  );

  // Magnitudes are taken only for signed division; negation wraps modulo 2^WIDTH.
  assign w_a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
  assign w_b_abs = (signed_div && b[WIDTH-1]) ? -b : b;
  assign w_quo   = {r_dvd[WIDTH-2:0], w_step_q};

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_rem    = r_rem;
    w_dvd    = r_dvd;
    w_dsr    = r_dsr;
    w_neg_q  = r_neg_q;
    w_neg_r  = r_neg_r;
    w_result = r_result;
    w_dz     = r_dz;
    w_ready  = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (!annul && start) begin
          if (b == '0) begin
            w_state  = DIV_DONE;
            w_result = '0;
            w_dz     = 1'b1;
            w_ready  = 1'b1;
          end else begin
            w_state = DIV_RUN;
            w_dvd   = w_a_abs;
            w_dsr   = w_b_abs;
            w_neg_q = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            w_neg_r = signed_div & a[WIDTH-1];
            w_rem   = '0;
            w_cnt   = '0;
            w_dz    = 1'b0;
            w_busy  = 1'b1;
          end
        end
      end
      DIV_RUN: begin
        if (annul) begin
          w_state = DIV_IDLE;
          w_cnt   = '0;
        end else begin
          w_rem = w_step_rem;
          w_dvd = w_quo;
          w_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_state  = DIV_DONE;
            w_ready  = 1'b1;
            w_result = {(r_neg_r ? -w_step_rem : w_step_rem),
                        (r_neg_q ? -w_quo : w_quo)};
          end else begin
            w_busy = 1'b1;
          end
        end
      end
      DIV_DONE: w_state = DIV_IDLE;
      default:  w_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_rem    <= w_rem;
      r_dvd    <= w_dvd;
      r_dsr    <= w_dsr;
      r_neg_q  <= w_neg_q;
      r_neg_r  <= w_neg_r;
      r_result <= w_result;
      r_ready  <= w_ready;
      r_busy   <= w_busy;
      r_dz     <= w_dz;
    end
  end

  assign result      = r_result;
  assign ready       = r_ready;
  assign busy        = r_busy;
  assign div_by_zero = r_dz;

endmodule
